// File: rtl/instr_fetch_unit.sv
// Fetch stage: captures the PC, keeps at most one instruction-memory read in flight,
// and holds the returned word for decode behind a valid/ready handshake.
module instr_fetch_unit #(
   parameter int          ADDR_W    = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              flush,
   output logic              pc_advance,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_misaligned
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, VALID} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr_q, addr_next;
   logic [31:0]       instr_next;
   logic [ADDR_W-1:0] instr_pc_next;
   logic              misaligned_next;
   logic              start_fetch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         addr_q           <= '0;
         instr_out        <= '0;
         instr_pc         <= '0;
         instr_misaligned <= 1'b0;
      end else begin
         state            <= state_next;
         addr_q           <= addr_next;
         instr_out        <= instr_next;
         instr_pc         <= instr_pc_next;
         instr_misaligned <= misaligned_next;
      end
   end

   // pc_advance is combinational in the data-return cycle so the PC has already
   // incremented by the time decode can complete the handshake.
   always_comb begin
      state_next      = state;
      addr_next       = addr_q;
      instr_next      = instr_out;
      instr_pc_next   = instr_pc;
      misaligned_next = instr_misaligned;
      pc_advance      = 1'b0;
      start_fetch     = 1'b0;

      case (state)
         IDLE: start_fetch = fetch_en && !flush;
         REQ: begin
            if (mem_gnt) begin
               state_next = flush ? DRAIN : WAIT;
            end else if (flush) begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               if (flush) begin
                  state_next = IDLE;
               end else begin
                  state_next      = VALID;
                  instr_next      = mem_rdata;
                  instr_pc_next   = addr_q;
                  misaligned_next = 1'b0;
                  pc_advance      = 1'b1;
               end
            end else if (flush) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (mem_rvalid) begin
               state_next = IDLE;
            end
         end
         VALID: begin
            if (flush) begin
               state_next = IDLE;
            end else if (instr_ready) begin
               if (fetch_en) begin
                  start_fetch = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // A misaligned PC never reaches memory; a NOP carries the fault flag instead.
      if (start_fetch) begin
         addr_next = pc_in;
         if (pc_in[1:0] != 2'b00) begin
            state_next      = VALID;
            instr_next      = NOP_INSTR;
            instr_pc_next   = pc_in;
            misaligned_next = 1'b1;
         end else begin
            state_next = REQ;
         end
      end
   end

   assign mem_req     = (state == REQ);
   assign mem_addr    = addr_q;
   assign instr_valid = (state == VALID);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_instr_fetch_unit;

   localparam int          ADDR_W = 32;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              reset;
   logic              fetch_en;
   logic [ADDR_W-1:0] pc_in;
   logic              flush;
   logic              pc_advance;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr_out;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_misaligned;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: a pending request, a granted read (possibly doomed), or a held instruction.
   bit                m_req, m_busy, m_drop, m_hold, m_mis;
   logic [ADDR_W-1:0] m_addr, m_pc;
   logic [31:0]       m_instr;

   bit                mem_pend;
   int                mem_cnt;
   logic [31:0]       mem_data;
   logic [ADDR_W-1:0] pc_reg;

   instr_fetch_unit #(.ADDR_W(ADDR_W), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_in(pc_in), .flush(flush),
      .pc_advance(pc_advance), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
      .instr_pc(instr_pc), .instr_misaligned(instr_misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic bit expAdvance();
      return m_busy && !m_drop && mem_rvalid && !flush;
   endfunction

   task automatic modelReset();
      m_req = 0; m_busy = 0; m_drop = 0; m_hold = 0; m_mis = 0;
      m_addr = '0; m_pc = '0; m_instr = '0;
   endtask

   task automatic modelStart(input logic [ADDR_W-1:0] pc);
      m_addr = pc;
      if (pc[1:0] != 2'b00) begin
         m_hold = 1; m_instr = NOP; m_pc = pc; m_mis = 1;
      end else begin
         m_req = 1;
      end
   endtask

   task automatic modelStep();
      if (m_req) begin
         if (mem_gnt) begin
            m_req = 0; m_busy = 1; m_drop = flush;
         end else if (flush) m_req = 0;
      end else if (m_busy) begin
         if (mem_rvalid) begin
            m_busy = 0;
            if (!m_drop && !flush) begin
               m_hold = 1; m_instr = mem_rdata; m_pc = m_addr; m_mis = 0;
            end
         end else if (flush) m_drop = 1;
      end else if (m_hold) begin
         if (flush) m_hold = 0;
         else if (instr_ready) begin
            m_hold = 0;
            if (fetch_en) modelStart(pc_in);
         end
      end else if (fetch_en && !flush) modelStart(pc_in);
   endtask

   task automatic checkOutput();
      chk("mem_req", mem_req, m_req);
      if (m_req) chk("mem_addr", mem_addr, m_addr);
      chk("pc_advance", pc_advance, expAdvance());
      chk("instr_valid", instr_valid, m_hold);
      if (m_hold) begin
         chk("instr_out", instr_out, m_instr);
         chk("instr_pc", instr_pc, m_pc);
         chk("instr_misaligned", instr_misaligned, m_mis);
      end
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic step();
      bit adv;
      #1;
      checkOutput();
      adv = expAdvance();
      modelStep();
      if (adv) pc_reg += 4;
      @(negedge clk);
   endtask

   task automatic pulseReset();
      #2 reset = 1'b1;
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_pc_advance", pc_advance, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr_out", instr_out, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_instr_misaligned", instr_misaligned, 0);
      modelReset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic applyStimulus();
      bit busy;
      logic [ADDR_W-1:0] tmp;
      busy = mem_pend;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (mem_pend) begin
         if (mem_cnt == 0) begin
            mem_rvalid = 1'b1; mem_rdata = mem_data; mem_pend = 0;
         end else mem_cnt--;
      end
      mem_gnt = mem_req && !busy && ($urandom_range(0, 2) != 0);
      if (mem_gnt) begin
         mem_pend = 1; mem_cnt = $urandom_range(0, 2); mem_data = $urandom;
      end
      flush       = ($urandom_range(0, 9) == 0);
      fetch_en    = ($urandom_range(0, 7) != 0);
      instr_ready = ($urandom_range(0, 9) < 6);
      pc_in       = pc_reg;
      tmp         = '0;
      if (tmp != 0) pc_reg = tmp;
   endtask

   initial begin
      bit redirect;
      logic [ADDR_W-1:0] target;
      reset = 1'b1; fetch_en = 0; pc_in = '0; flush = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; instr_ready = 0;
      mem_pend = 0; mem_cnt = 0; mem_data = '0; pc_reg = '0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      chk("init_mem_req", mem_req, 0);
      chk("init_instr_valid", instr_valid, 0);
      chk("init_instr_out", instr_out, 0);
      chk("init_mem_addr", mem_addr, 0);
      reset = 1'b0;

      $display("[TB] basic fetch and back-pressure");
      fetch_en = 1; pc_in = 32'h100; step();
      #1 chk("basic_req", mem_req, 1); chk("basic_addr", mem_addr, 32'h100);
      mem_gnt = 1; step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
      #1 chk("basic_advance", pc_advance, 1);
      step();
      mem_rvalid = 0; pc_in = 32'h104; instr_ready = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid", instr_valid, 1);
         chk("bp_instr", instr_out, 32'h0050_0093);
         chk("bp_pc", instr_pc, 32'h100);
         chk("bp_no_req", mem_req, 0);
         chk("bp_no_adv", pc_advance, 0);
         step();
      end
      instr_ready = 1; step();
      instr_ready = 0;
      #1 chk("bp_next_req", mem_req, 1); chk("bp_next_addr", mem_addr, 32'h104);
      mem_gnt = 1; step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1111_1111; step();
      mem_rvalid = 0; pc_in = 32'h200; instr_ready = 1; step();
      instr_ready = 0;

      $display("[TB] grant stall");
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall_req", mem_req, 1);
         chk("stall_addr", mem_addr, 32'h200);
         step();
      end
      mem_gnt = 1; step();
      mem_gnt = 0;
      #1 chk("wait_no_req", mem_req, 0);

      $display("[TB] flush while waiting");
      flush = 1; step();
      flush = 0; pc_in = 32'h400;
      for (int i = 0; i < 2; i++) begin
         #1 chk("drain_no_adv", pc_advance, 0); chk("drain_no_valid", instr_valid, 0);
         step();
      end
      mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
      #1 chk("drain_discard_adv", pc_advance, 0);
      step();
      mem_rvalid = 0;
      #1 chk("drain_after_valid", instr_valid, 0); chk("drain_after_req", mem_req, 0);
      step();
      #1 chk("refetch_req", mem_req, 1); chk("refetch_addr", mem_addr, 32'h400);
      mem_gnt = 1; step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00A0_0113; step();
      mem_rvalid = 0;
      #1 chk("refetch_instr", instr_out, 32'h00A0_0113); chk("refetch_pc", instr_pc, 32'h400);

      $display("[TB] misaligned pc");
      pc_in = 32'h102; instr_ready = 1; step();
      instr_ready = 0;
      #1;
      chk("mis_no_req", mem_req, 0);
      chk("mis_valid", instr_valid, 1);
      chk("mis_instr", instr_out, NOP);
      chk("mis_flag", instr_misaligned, 1);
      chk("mis_pc", instr_pc, 32'h102);
      chk("mis_no_adv", pc_advance, 0);
      step();
      flush = 1; step();
      flush = 0; pc_in = 32'h300;
      #1 chk("mis_flushed", instr_valid, 0);
      step();
      mem_gnt = 1; step();
      mem_gnt = 0;

      $display("[TB] async reset mid-transaction");
      pulseReset();
      fetch_en = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
      #1 chk("late_rvalid_adv", pc_advance, 0);
      step();
      mem_rvalid = 0;
      #1 chk("late_rvalid_valid", instr_valid, 0); chk("late_rvalid_req", mem_req, 0);
      fetch_en = 1; pc_in = 32'h500; step();
      #1 chk("post_rst_addr", mem_addr, 32'h500);
      mem_gnt = 1; step();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0010_0073; step();
      mem_rvalid = 0;
      #1;
      chk("post_rst_valid", instr_valid, 1);
      chk("post_rst_instr", instr_out, 32'h0010_0073);
      chk("post_rst_pc", instr_pc, 32'h500);
      instr_ready = 1; fetch_en = 0; step();

      $display("[TB] randomized traffic");
      mem_pend = 0;
      pulseReset();
      pc_reg = 32'h1000;
      for (int i = 0; i < 3000; i++) begin
         applyStimulus();
         redirect = flush;
         step();
         if (redirect) begin
            target = $urandom;
            target[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            pc_reg = target;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
